// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte FIFO, error counter, idle frame detect.
// Define UART_RX_AUTOBAUD_EN for the HUNT/LOCKED baud search.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH   = 16,
  parameter int IDLE_TIMEOUT = 20000
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic [7:0]                      rx_data_i,
  input  logic                            rx_done_i,
  input  logic                            rx_error_i,
  input  logic [3:0]                      baud_sel_i,
  output logic [3:0]                      baud_set_o,
  input  logic                            rd_en_i,
  output logic [7:0]                      rd_data_o,
  output logic                            empty_o,
  output logic                            full_o,
  output logic [$clog2(FIFO_DEPTH):0]     count_o,
  output logic                            overflow_o,
  output logic [7:0]                      err_cnt_o,
  output logic                            frame_end_o,
  output logic                            locked_o,
  input  logic                            clr_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  logic          good;
  logic          accept;
  logic          push_req;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [IW-1:0] idle_q;
  logic          armed_q;

  assign good     = rx_done_i & ~rx_error_i;
  assign push_req = good & accept;
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop      = rd_en_i & ~empty_o;
  // A pop frees the slot the same cycle, so a full FIFO still takes the byte
  assign push     = push_req & (~full_o | pop);
  assign count_o  = count_q;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rd_data_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_o <= mem[rd_ptr];
      end
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
      err_cnt_o  <= '0;
    end else if (clr_i) begin
      overflow_o <= 1'b0;
      err_cnt_o  <= '0;
    end else begin
      if (push_req && full_o && !pop) overflow_o <= 1'b1;
      if (rx_error_i && err_cnt_o != 8'hFF)
        err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

  // Counter only runs while armed, so one pulse per burst of traffic
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      idle_q      <= '0;
      armed_q     <= 1'b0;
      frame_end_o <= 1'b0;
    end else begin
      frame_end_o <= 1'b0;
      if (good) begin
        idle_q  <= '0;
        armed_q <= 1'b1;
      end else if (armed_q) begin
        if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
          frame_end_o <= 1'b1;
          armed_q     <= 1'b0;
          idle_q      <= '0;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_AUTOBAUD_EN
  typedef enum logic {HUNT, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [3:0] baud_q, baud_d;
  logic [1:0] good_q, good_d;
  logic [2:0] err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      baud_q  <= 4'd1;
      good_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    good_d  = good_q;
    err_d   = err_q;
    unique case (state_q)
      HUNT: begin
        if (rx_error_i) begin
          baud_d = (baud_q >= 4'd5) ? 4'd1 : baud_q + 4'd1;
          good_d = '0;
        end else if (good) begin
          if (good_q == 2'd3) begin
            state_d = LOCKED;
            good_d  = '0;
            err_d   = '0;
          end else begin
            good_d = good_q + 2'd1;
          end
        end
      end
      LOCKED: begin
        if (rx_error_i) begin
          if (err_q == 3'd7) begin
            state_d = HUNT;
            err_d   = '0;
            good_d  = '0;
          end else begin
            err_d = err_q + 3'd1;
          end
        end else if (good) begin
          err_d = '0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign accept     = (state_q == LOCKED);
  assign locked_o   = accept;
  assign baud_set_o = baud_q;
`else
  logic [3:0] baud_q;
  logic [3:0] baud_d;

  // Codes outside 1..4 select the fastest rate, code 5
  always_comb begin
    baud_d = 4'd5;
    if (baud_sel_i >= 4'd1 && baud_sel_i <= 4'd4) baud_d = baud_sel_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) baud_q <= 4'd1;
    else        baud_q <= baud_d;
  end

  assign accept     = 1'b1;
  assign locked_o   = 1'b1;
  assign baud_set_o = baud_q;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO depth in bytes, power of two.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 20000, idle clk_i cycles after the last byte that end a frame.
REQ-003 SHALL have port clk_i, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port rx_data_i, input, 8, byte from the UART receiver.
REQ-006 SHALL have port rx_done_i, input, 1, one-cycle byte-received pulse from the receiver.
REQ-007 SHALL have port rx_error_i, input, 1, start/data glitch error pulse from the receiver.
REQ-008 SHALL have port baud_sel_i, input, 4, software baud code: 1=9600, 2=19200, 3=38400, 4=57600, other=115200.
REQ-009 SHALL have port baud_set_o, output, 4, registered baud code driven to the receiver.
REQ-010 SHALL have port rd_en_i, input, 1, FIFO pop request.
REQ-011 SHALL have port rd_data_o, output, 8, popped byte.
REQ-012 SHALL have port empty_o / full_o, output, 1 each, FIFO status.
REQ-013 SHALL have port count_o, output, log2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-014 SHALL have port overflow_o, output, 1, sticky flag: a byte was dropped because the FIFO was full.
REQ-015 SHALL have port err_cnt_o, output, 8, saturating receive-error count.
REQ-016 SHALL have port frame_end_o, output, 1, one-cycle pulse marking an idle-timeout frame boundary.
REQ-017 SHALL have port locked_o, output, 1, baud lock indication.
REQ-018 SHALL have port clr_i, input, 1, synchronous clear of overflow_o and err_cnt_o.

Function
REQ-019 SHALL define a good byte as rx_done_i=1 with rx_error_i=0; when both are 1 in the same cycle, the error wins and the byte is discarded.
REQ-020 SHALL push each accepted good byte into the FIFO in the same cycle as rx_done_i; count_o SHALL update on the next edge.
REQ-021 SHALL drop a good byte that arrives while full_o=1 without a simultaneous pop, and SHALL set overflow_o.
REQ-022 SHALL accept both a push and a pop when they coincide while full, leaving count unchanged.
REQ-023 SHALL ignore a pop on empty; a simultaneous push on empty SHALL be accepted.
REQ-024 SHALL register rd_data_o one cycle after an accepted pop and hold it until the next accepted pop.
REQ-025 SHALL wrap the read and write pointers modulo FIFO_DEPTH.
REQ-026 SHALL increment err_cnt_o on each rx_error_i pulse and saturate it at 255.
REQ-027 SHALL give clr_i priority over a same-cycle increment or overflow set.
REQ-028 SHALL count idle cycles from 0 after each good byte; frame_end_o SHALL pulse once when the count equals IDLE_TIMEOUT-1, and only if at least one good byte arrived since the previous pulse.
REQ-029 SHALL restart the idle count on a good byte that arrives in the same cycle as the timeout, with no pulse.

Reset
REQ-030 SHALL, during rst_n=0: empty the FIFO (empty_o=1, full_o=0, count_o=0); clear rd_data_o, overflow_o, err_cnt_o, frame_end_o and the idle counter; set baud_set_o=1.
REQ-031 SHALL drive locked_o=0 during reset when UART_RX_AUTOBAUD_EN is defined, and 1 otherwise.
REQ-032 SHALL abort any FIFO write, hunt or timeout in progress when reset is asserted mid-operation; no partial state SHALL survive.

Configuration
REQ-033 SHALL, with macro UART_RX_AUTOBAUD_EN defined, implement FSM HUNT/LOCKED, starting in HUNT at reset:
- HUNT: each rx_error_i advances baud_set_o 1->2->3->4->5->1 and clears the good-run counter.
- HUNT: 4 consecutive good bytes -> LOCKED.
- HUNT: good bytes are not pushed to the FIFO.
- LOCKED: bytes are pushed normally; 8 consecutive rx_error_i without an intervening good byte -> HUNT, with baud_set_o retained.
- locked_o=1 exactly while in LOCKED; baud_sel_i is ignored.
REQ-034 SHALL, without UART_RX_AUTOBAUD_EN:
- register baud_set_o from baud_sel_i each cycle (one-cycle latency);
- tie locked_o to 1;
- contain no FSM.

Verification
REQ-035 SHALL test basic push/pop: push bytes 0x55 then 0xA3, then pulse rd_en_i twice -> rd_data_o=0x55 then 0xA3, one cycle after each pop; empty_o=1 at the end.
REQ-036 SHALL test overflow: push 17 bytes with no reads (FIFO_DEPTH=16) -> full_o=1, count_o=16, overflow_o=1, byte 17 lost; clr_i -> overflow_o=0.
REQ-037 SHALL test error priority: rx_done_i with rx_error_i in the same cycle, 300 times -> no push, err_cnt_o=255.
REQ-038 SHALL test frame end: 3 good bytes, then IDLE_TIMEOUT idle cycles -> exactly one frame_end_o pulse; a further 2*IDLE_TIMEOUT idle cycles -> no more pulses.
REQ-039 SHALL test autobaud (macro defined): 2 errors then 4 good bytes -> baud_set_o=3, locked_o=1, FIFO empty; then 8 errors -> locked_o=0, baud_set_o=3.
REQ-040 SHALL test reset mid-operation: assert rst_n=0 while count_o=5 -> count_o=0, empty_o=1, baud_set_o=1 immediately (asynchronous).
